// File: rtl/xor_cipher_nx.sv
// Word-wide XOR stream cipher: Galois LFSR or external-key keystream, valid/ready data path,
// double-buffered serial config chain. Optional readback on cfg_o: XOR_CIPHER_NX_READBACK_EN.
module xor_cipher_nx #(
  parameter int                LFSR_W    = 32,
  parameter int                DATA_W    = 8,
  parameter logic [LFSR_W-1:0] TAPS_RST  = 32'h60,
  parameter logic [LFSR_W-1:0] STATE_RST = 32'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_i,
  output logic              cfg_o,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] ext_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  localparam int CFG_W = 2*LFSR_W + 2;
  localparam int CW    = $clog2(CFG_W + 1);

  typedef struct packed {
    logic              k_sel;
    logic              bypass;
    logic [LFSR_W-1:0] taps;
    logic [LFSR_W-1:0] state;
  } cfg_t;

  localparam cfg_t CFG_RST = '{k_sel: 1'b0, bypass: 1'b0, taps: TAPS_RST, state: STATE_RST};

  typedef enum logic {RUN, CFG} st_t;

  st_t               st;
  cfg_t              shadow, active;
  logic [CW-1:0]     cnt;
  logic [LFSR_W-1:0] s_walk, state_adv;
  logic [DATA_W-1:0] ks;
  logic              accept;

  assign in_ready = (st == RUN) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // DATA_W Galois steps unrolled; ks[i] is the bit shifted out on step i
  always_comb begin
    s_walk = active.state;
    ks     = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ks[i]  = s_walk[0];
      s_walk = (s_walk >> 1) ^ (s_walk[0] ? active.taps : '0);
    end
    state_adv = s_walk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      shadow    <= CFG_RST;
      active    <= CFG_RST;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;

      if (accept) begin
        out_valid <= 1'b1;
        if (active.bypass)     out_data <= in_data;
        else if (active.k_sel) out_data <= in_data ^ ext_k;
        else begin
          out_data     <= in_data ^ ks;
          active.state <= state_adv;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (st)
        RUN: if (cfg_en) begin
          st     <= CFG;
          shadow <= cfg_t'({cfg_i, shadow[CFG_W-1:1]});
          cnt    <= CW'(1);
        end
        CFG: if (cfg_en) begin
          shadow <= cfg_t'({cfg_i, shadow[CFG_W-1:1]});
          if (cnt < CW'(CFG_W)) cnt <= cnt + 1'b1;
        end else begin
          st <= RUN;
          // a short chain never reaches the data path; shadow is resynced to what is running
          if (cnt >= CW'(CFG_W)) begin
            active   <= shadow;
            cfg_done <= 1'b1;
            cfg_err  <= 1'b0;
          end else begin
            shadow  <= active;
            cfg_err <= 1'b1;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

`ifdef XOR_CIPHER_NX_READBACK_EN
  assign cfg_o = shadow[0];
`else
  assign cfg_o = 1'b0;
`endif

endmodule
